// File: rtl/iserdes_align_pkg.sv
// rtl/iserdes_align_pkg.sv - shared types, widths and window helper for the iserdes word aligner
//
// Purpose : lane FSM state type, counter/offset widths and the barrel-shift
//           window function used by every lane.
// Ports   : none (package).
// Config  : ISERDES_ALIGN_ERRCNT_EN uses ERR_W for the per-lane error counter.

package iserdes_align_pkg;

  localparam int OFF_W = 3;
  localparam int CNT_W = 8;
  localparam int ERR_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    SLIP   = 3'd2,
    WAIT   = 3'd3,
    LOCKED = 3'd4,
    FAIL   = 3'd5
  } lane_state_e;

  // Selects width bits starting at bit off of {cur, prev}. Inputs are
  // zero-extended to 8 bits; only the low width bits of the result matter.
  function automatic logic [7:0] rotate_window(
    input logic [7:0]       cur,
    input logic [7:0]       prev,
    input logic [OFF_W-1:0] off,
    input int               width
  );
    logic [15:0] cat;
    cat = ({8'h00, cur} << width) | {8'h00, prev};
    cat = cat >> off;
    return cat[7:0];
  endfunction

endpackage

// File: rtl/iserdes_align_lane.sv
// rtl/iserdes_align_lane.sv - single-lane training-word search, barrel shifter and lock FSM
//
// Purpose : per-lane prev_word register, offset window, alignment FSM and counters.
// Ports   : clk, rst_n (async active-low), align_start, valid, data[W]
//           word[W] (registered aligned word), locked, fail, offset[OFF_W]
//           chk / errcnt[ERR_W] only with ISERDES_ALIGN_ERRCNT_EN.

module iserdes_align_lane
  import iserdes_align_pkg::*;
#(
  parameter int         W         = 8,
  parameter logic [7:0] PATTERN   = 8'hE4,
  parameter int         LOCK_CNT  = 16,
  parameter int         SLIP_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             align_start,
  input  logic             valid,
  input  logic [W-1:0]     data,
`ifdef ISERDES_ALIGN_ERRCNT_EN
  input  logic             chk,
  output logic [ERR_W-1:0] errcnt,
`endif
  output logic [W-1:0]     word,
  output logic             locked,
  output logic             fail,
  output logic [OFF_W-1:0] offset
);

  localparam logic [W-1:0]     PAT_W   = PATTERN[W-1:0];
  localparam logic [CNT_W-1:0] LOCK_C  = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] WAIT_C  = CNT_W'(SLIP_WAIT);
  localparam logic [CNT_W-1:0] ATT_MAX = CNT_W'(2 * W);
  localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(W - 1);

  lane_state_e      state_q, state_d;
  logic [W-1:0]     prev_q;
  logic [W-1:0]     word_q;
  logic [OFF_W-1:0] off_q, off_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic [CNT_W-1:0] att_q, att_d;
  logic [CNT_W-1:0] wait_q, wait_d;

  logic [7:0]       cur8, prev8, win8;
  logic [W-1:0]     window;
  logic             hit;

  always_comb begin
    cur8  = '0;
    prev8 = '0;
    cur8[W-1:0]  = data;
    prev8[W-1:0] = prev_q;
  end

  assign win8   = rotate_window(cur8, prev8, off_q, W);
  assign window = win8[W-1:0];
  assign hit    = (window == PAT_W);

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    match_d = match_q;
    att_d   = att_q;
    wait_d  = wait_q;
    if (align_start) begin
      // Restart wins over whatever this cycle's word would have done.
      state_d = CHECK;
      off_d   = '0;
      match_d = '0;
      att_d   = '0;
      wait_d  = '0;
    end else if (valid) begin
      case (state_q)
        IDLE: begin
          state_d = CHECK;
          off_d   = '0;
          match_d = '0;
          att_d   = '0;
          wait_d  = '0;
        end
        CHECK: begin
          if (hit) begin
            match_d = match_q + CNT_W'(1);
            if (match_d == LOCK_C) state_d = LOCKED;
          end else begin
            match_d = '0;
            state_d = SLIP;
          end
        end
        SLIP: begin
          off_d  = (off_q == OFF_MAX) ? '0 : off_q + OFF_W'(1);
          att_d  = att_q + CNT_W'(1);
          wait_d = '0;
          state_d = (att_d == ATT_MAX) ? FAIL : WAIT;
        end
        WAIT: begin
          // The word arriving in WAIT is always discarded, so a zero wait
          // still costs one valid word before checking resumes.
          wait_d = wait_q + CNT_W'(1);
          if (wait_d >= WAIT_C) state_d = CHECK;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      off_q   <= '0;
      match_q <= '0;
      att_q   <= '0;
      wait_q  <= '0;
      prev_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      match_q <= match_d;
      att_q   <= att_d;
      wait_q  <= wait_d;
      if (valid) begin
        prev_q <= data;
        word_q <= window;
      end
    end
  end

  assign word   = word_q;
  assign locked = (state_q == LOCKED);
  assign fail   = (state_q == FAIL);
  assign offset = off_q;

`ifdef ISERDES_ALIGN_ERRCNT_EN
  logic [ERR_W-1:0] err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (align_start) begin
      err_q <= '0;
    end else if (valid && chk && (state_q == LOCKED) && !hit && (err_q != '1)) begin
      err_q <= err_q + ERR_W'(1);
    end
  end

  assign errcnt = err_q;
`endif

endmodule

// File: rtl/iserdes_word_align.sv
// rtl/iserdes_word_align.sv - multi-lane fabric word aligner behind an iserdes bank
//
// Purpose : instantiates one alignment lane per iserdes lane, delays VALID by
//           one clock and registers the AND of all lane lock flags.
// Ports   : CLK_I, RSTN_I (async active-low), ALIGN_START_I, VALID_I,
//           DATA_I[C_LANES*C_DATA_WIDTH] (lane n at [n*W +: W], bit 0 oldest)
//           VALID_O, DATA_O, LOCKED_O[C_LANES], FAIL_O[C_LANES], ALL_LOCKED_O,
//           OFFSET_O[C_LANES*3]
// Config  : ISERDES_ALIGN_ERRCNT_EN adds CHK_I and ERRCNT_O[C_LANES*16].

module iserdes_word_align
  import iserdes_align_pkg::*;
#(
  parameter int         C_LANES         = 4,
  parameter int         C_DATA_WIDTH    = 8,
  parameter logic [7:0] C_TRAIN_PATTERN = 8'hE4,
  parameter int         C_LOCK_CNT      = 16,
  parameter int         C_SLIP_WAIT     = 4
) (
  input  logic                            CLK_I,
  input  logic                            RSTN_I,
  input  logic                            ALIGN_START_I,
  input  logic                            VALID_I,
  input  logic [C_LANES*C_DATA_WIDTH-1:0] DATA_I,
`ifdef ISERDES_ALIGN_ERRCNT_EN
  input  logic                            CHK_I,
  output logic [C_LANES*ERR_W-1:0]        ERRCNT_O,
`endif
  output logic                            VALID_O,
  output logic [C_LANES*C_DATA_WIDTH-1:0] DATA_O,
  output logic [C_LANES-1:0]              LOCKED_O,
  output logic [C_LANES-1:0]              FAIL_O,
  output logic                            ALL_LOCKED_O,
  output logic [C_LANES*OFF_W-1:0]        OFFSET_O
);

  localparam int W = C_DATA_WIDTH;

  for (genvar n = 0; n < C_LANES; n++) begin : g_lane
    iserdes_align_lane #(
      .W         (W),
      .PATTERN   (C_TRAIN_PATTERN),
      .LOCK_CNT  (C_LOCK_CNT),
      .SLIP_WAIT (C_SLIP_WAIT)
    ) u_lane (
      .clk         (CLK_I),
      .rst_n       (RSTN_I),
      .align_start (ALIGN_START_I),
      .valid       (VALID_I),
      .data        (DATA_I[n*W +: W]),
`ifdef ISERDES_ALIGN_ERRCNT_EN
      .chk         (CHK_I),
      .errcnt      (ERRCNT_O[n*ERR_W +: ERR_W]),
`endif
      .word        (DATA_O[n*W +: W]),
      .locked      (LOCKED_O[n]),
      .fail        (FAIL_O[n]),
      .offset      (OFFSET_O[n*OFF_W +: OFF_W])
    );
  end

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      VALID_O      <= 1'b0;
      ALL_LOCKED_O <= 1'b0;
    end else begin
      VALID_O      <= VALID_I;
      ALL_LOCKED_O <= &LOCKED_O;
    end
  end

endmodule
